// File: rtl/bootloader_reset_ctrl.sv
// Bootloader reset/attach controller: USB power-on, bus reset,
// host-presence timeout and detach-then-boot sequencing.
module bootloader_reset_ctrl #(
    parameter int unsigned POR_CYCLES          = 4800,
    parameter int unsigned SE0_RESET_CYCLES    = 120,
    parameter int unsigned HOST_TIMEOUT_CYCLES = 48000000,
    parameter int unsigned DETACH_CYCLES       = 16
) (
    input  logic clk_48mhz,
    input  logic reset_n,
    input  logic dp_rx,
    input  logic dn_rx,
    input  logic sof_valid,
    input  logic boot_to_user_design,
    output logic usb_reset,
    output logic usb_pu_en,
    output logic bus_reset_evt,
    output logic host_presence_timeout,
    output logic boot
);

    typedef enum logic [2:0] {
        S_POR,
        S_ATTACH,
        S_BUSRST,
        S_DETACH,
        S_BOOT
    } state_t;

    state_t      state;
    logic [1:0]  rel_sync;
    logic        run;
    logic [1:0]  dp_sync;
    logic [1:0]  dn_sync;
    logic        se0;
    logic [31:0] por_cnt;
    logic [31:0] se0_cnt;
    logic [31:0] host_cnt;
    logic [31:0] det_cnt;

    // Two-flop release of reset so POR counting starts cleanly
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) rel_sync <= 2'b00;
        else          rel_sync <= {rel_sync[0], 1'b1};
    end

    assign run = rel_sync[1];

    // Two-flop synchronisers for the raw USB line samples
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            dp_sync <= 2'b00;
            dn_sync <= 2'b00;
        end else begin
            dp_sync <= {dp_sync[0], dp_rx};
            dn_sync <= {dn_sync[0], dn_rx};
        end
    end

    assign se0 = ~dp_sync[1] & ~dn_sync[1];

    // Sequencing FSM; every output is a flop updated with the state
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= S_POR;
            por_cnt               <= '0;
            se0_cnt               <= '0;
            host_cnt              <= '0;
            det_cnt               <= '0;
            usb_reset             <= 1'b1;
            usb_pu_en             <= 1'b0;
            bus_reset_evt         <= 1'b0;
            host_presence_timeout <= 1'b0;
            boot                  <= 1'b0;
        end else begin
            bus_reset_evt <= 1'b0;
            unique case (state)
                S_POR: begin
                    if (run) begin
                        if (por_cnt == POR_CYCLES - 32'd1) begin
                            state     <= S_ATTACH;
                            por_cnt   <= '0;
                            se0_cnt   <= '0;
                            host_cnt  <= '0;
                            usb_reset <= 1'b0;
                            usb_pu_en <= 1'b1;
                        end else begin
                            por_cnt <= por_cnt + 32'd1;
                        end
                    end
                end
                S_ATTACH: begin
                    if (boot_to_user_design) begin
                        state     <= S_DETACH;
                        det_cnt   <= '0;
                        usb_reset <= 1'b1;
                        usb_pu_en <= 1'b0;
                    end else if (!sof_valid &&
                                 host_cnt == HOST_TIMEOUT_CYCLES) begin
                        state                 <= S_DETACH;
                        det_cnt               <= '0;
                        usb_reset             <= 1'b1;
                        usb_pu_en             <= 1'b0;
                        host_presence_timeout <= 1'b1;
                    end else if (se0 &&
                                 se0_cnt >= SE0_RESET_CYCLES - 32'd1) begin
                        state         <= S_BUSRST;
                        se0_cnt       <= '0;
                        host_cnt      <= '0;
                        usb_reset     <= 1'b1;
                        bus_reset_evt <= 1'b1;
                    end else begin
                        if (!se0)
                            se0_cnt <= '0;
                        else if (se0_cnt < SE0_RESET_CYCLES)
                            se0_cnt <= se0_cnt + 32'd1;
                        if (sof_valid)
                            host_cnt <= '0;
                        else if (host_cnt < HOST_TIMEOUT_CYCLES)
                            host_cnt <= host_cnt + 32'd1;
                    end
                end
                S_BUSRST: begin
                    host_cnt <= '0;
                    if (boot_to_user_design) begin
                        state     <= S_DETACH;
                        det_cnt   <= '0;
                        usb_reset <= 1'b1;
                        usb_pu_en <= 1'b0;
                    end else if (!se0) begin
                        state     <= S_ATTACH;
                        se0_cnt   <= '0;
                        usb_reset <= 1'b0;
                    end
                end
                S_DETACH: begin
                    if (det_cnt >= DETACH_CYCLES - 32'd1) begin
                        state <= S_BOOT;
                        boot  <= 1'b1;
                    end else begin
                        det_cnt <= det_cnt + 32'd1;
                    end
                end
                S_BOOT: begin
                    boot <= 1'b1;
                end
                default: begin
                    state <= S_POR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bootloader_reset_ctrl.sv
// Directed self-checking bench for bootloader_reset_ctrl
// with small timing parameters.
module tb_bootloader_reset_ctrl;

    logic clk_48mhz = 1'b0;
    logic reset_n = 1'b1;
    logic dp_rx = 1'b1;
    logic dn_rx = 1'b0;
    logic sof_valid = 1'b0;
    logic boot_to_user_design = 1'b0;
    logic usb_reset;
    logic usb_pu_en;
    logic bus_reset_evt;
    logic host_presence_timeout;
    logic boot;

    int checks = 0;
    int failures = 0;

    bootloader_reset_ctrl #(
        .POR_CYCLES(8),
        .SE0_RESET_CYCLES(4),
        .HOST_TIMEOUT_CYCLES(50),
        .DETACH_CYCLES(3)
    ) dut (
        .clk_48mhz(clk_48mhz),
        .reset_n(reset_n),
        .dp_rx(dp_rx),
        .dn_rx(dn_rx),
        .sof_valid(sof_valid),
        .boot_to_user_design(boot_to_user_design),
        .usb_reset(usb_reset),
        .usb_pu_en(usb_pu_en),
        .bus_reset_evt(bus_reset_evt),
        .host_presence_timeout(host_presence_timeout),
        .boot(boot)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic tick;
        @(posedge clk_48mhz);
        #1;
    endtask

    // Async reset, reset-state outputs, then 10-cycle POR
    task automatic test_reset_por(input string tag, input bit pulse_btu);
        int first_pu;
        int bad;
        dp_rx = 1'b1;
        dn_rx = 1'b0;
        sof_valid = 1'b0;
        boot_to_user_design = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({usb_reset, usb_pu_en, bus_reset_evt,
             host_presence_timeout, boot} !== 5'b10000) begin
            failures++;
            $display("FAIL %s_reset_outs: got %b expected 10000", tag,
                     {usb_reset, usb_pu_en, bus_reset_evt,
                      host_presence_timeout, boot});
        end
        tick;
        tick;
        reset_n = 1'b1;
        first_pu = 0;
        bad = 0;
        for (int i = 1; i <= 12; i++) begin
            boot_to_user_design = pulse_btu && i >= 2 && i <= 6;
            tick;
            if (usb_pu_en === 1'b1 && first_pu == 0) first_pu = i;
            if (usb_reset !== ~usb_pu_en) bad++;
        end
        boot_to_user_design = 1'b0;
        checks++;
        if (first_pu !== 10) begin
            failures++;
            $display("FAIL %s_por_len: got %0d expected 10", tag, first_pu);
        end
        checks++;
        if (bad !== 0 || usb_pu_en !== 1'b1 || usb_reset !== 1'b0) begin
            failures++;
            $display("FAIL %s_attach_outs: got bad=%0d pu=%b rst=%b expected 0 1 0",
                     tag, bad, usb_pu_en, usb_reset);
        end
    endtask

    task automatic test_short_se0;
        int evts = 0;
        dp_rx = 1'b0;
        dn_rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (bus_reset_evt === 1'b1) evts++;
        end
        dp_rx = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (bus_reset_evt === 1'b1) evts++;
        end
        checks++;
        if (evts !== 0 || usb_reset !== 1'b0) begin
            failures++;
            $display("FAIL short_se0: got evts=%0d rst=%b expected 0 0",
                     evts, usb_reset);
        end
    endtask

    task automatic test_bus_reset;
        int evts = 0;
        int first = 0;
        dp_rx = 1'b0;
        dn_rx = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (bus_reset_evt === 1'b1) begin
                evts++;
                if (first == 0) first = i;
            end
            if (i == 7) begin
                checks++;
                if (usb_reset !== 1'b1 || usb_pu_en !== 1'b1) begin
                    failures++;
                    $display("FAIL busrst_outs: got rst=%b pu=%b expected 1 1",
                             usb_reset, usb_pu_en);
                end
            end
        end
        dp_rx = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick;
            if (bus_reset_evt === 1'b1) evts++;
            checks++;
            if (usb_reset !== (i < 3)) begin
                failures++;
                $display("FAIL busrst_exit_%0d: got %b expected %b",
                         i, usb_reset, i < 3);
            end
        end
        checks++;
        if (evts !== 1 || first !== 6) begin
            failures++;
            $display("FAIL busrst_evt: got n=%0d at=%0d expected 1 at 6",
                     evts, first);
        end
    endtask

    task automatic test_timeout;
        int bad = 0;
        int t_to = 0;
        int t_pu = 0;
        int t_boot = 0;
        sof_valid = 1'b1;
        tick;
        sof_valid = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 39; i++) begin
                tick;
                if (host_presence_timeout !== 1'b0) bad++;
            end
            sof_valid = 1'b1;
            tick;
            sof_valid = 1'b0;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL sof_keepalive: got %0d timeout cycles expected 0", bad);
        end
        for (int n = 1; n <= 54; n++) begin
            tick;
            if (host_presence_timeout === 1'b1 && t_to == 0) t_to = n;
            if (usb_pu_en === 1'b0 && t_pu == 0) t_pu = n;
            if (boot === 1'b1 && t_boot == 0) t_boot = n;
        end
        checks++;
        if (t_to !== 51 || t_pu !== 51) begin
            failures++;
            $display("FAIL timeout_time: got to=%0d pu=%0d expected 51 51",
                     t_to, t_pu);
        end
        checks++;
        if (t_boot !== 54) begin
            failures++;
            $display("FAIL timeout_boot: got %0d expected 54", t_boot);
        end
        for (int i = 0; i < 5; i++) tick;
        checks++;
        if (host_presence_timeout !== 1'b1 || boot !== 1'b1) begin
            failures++;
            $display("FAIL timeout_sticky: got to=%b boot=%b expected 1 1",
                     host_presence_timeout, boot);
        end
    endtask

    task automatic test_sof_threshold;
        int bad = 0;
        int t_to = 0;
        sof_valid = 1'b1;
        tick;
        sof_valid = 1'b0;
        for (int n = 1; n <= 50; n++) begin
            tick;
            if (host_presence_timeout !== 1'b0) bad++;
        end
        sof_valid = 1'b1;
        tick;
        sof_valid = 1'b0;
        checks++;
        if (bad !== 0 || host_presence_timeout !== 1'b0 || usb_pu_en !== 1'b1) begin
            failures++;
            $display("FAIL sof_at_thresh: got bad=%0d to=%b pu=%b expected 0 0 1",
                     bad, host_presence_timeout, usb_pu_en);
        end
        for (int n = 1; n <= 52; n++) begin
            tick;
            if (host_presence_timeout === 1'b1 && t_to == 0) t_to = n;
        end
        checks++;
        if (t_to !== 51) begin
            failures++;
            $display("FAIL thresh_rearm: got %0d expected 51", t_to);
        end
    endtask

    task automatic test_boot_in_busrst;
        int bad = 0;
        dp_rx = 1'b0;
        dn_rx = 1'b0;
        for (int i = 1; i <= 6; i++) tick;
        checks++;
        if (bus_reset_evt !== 1'b1) begin
            failures++;
            $display("FAIL btu_enter_busrst: got %b expected 1", bus_reset_evt);
        end
        boot_to_user_design = 1'b1;
        tick;
        boot_to_user_design = 1'b0;
        dp_rx = 1'b1;
        checks++;
        if (usb_pu_en !== 1'b0 || usb_reset !== 1'b1 || boot !== 1'b0) begin
            failures++;
            $display("FAIL btu_detach: got pu=%b rst=%b boot=%b expected 0 1 0",
                     usb_pu_en, usb_reset, boot);
        end
        tick;
        tick;
        checks++;
        if (boot !== 1'b0) begin
            failures++;
            $display("FAIL btu_boot_early: got %b expected 0", boot);
        end
        tick;
        checks++;
        if (boot !== 1'b1) begin
            failures++;
            $display("FAIL btu_boot: got %b expected 1", boot);
        end
        for (int i = 0; i < 1000; i++) begin
            tick;
            if (boot !== 1'b1 || usb_pu_en !== 1'b0 ||
                usb_reset !== 1'b1 || bus_reset_evt !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL boot_hold: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_boot_vs_se0;
        int evts = 0;
        dp_rx = 1'b0;
        dn_rx = 1'b0;
        for (int i = 1; i <= 5; i++) tick;
        boot_to_user_design = 1'b1;
        tick;
        boot_to_user_design = 1'b0;
        if (bus_reset_evt === 1'b1) evts++;
        checks++;
        if (usb_pu_en !== 1'b0 || usb_reset !== 1'b1) begin
            failures++;
            $display("FAIL btu_vs_se0_detach: got pu=%b rst=%b expected 0 1",
                     usb_pu_en, usb_reset);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            if (bus_reset_evt === 1'b1) evts++;
        end
        checks++;
        if (evts !== 0 || boot !== 1'b1) begin
            failures++;
            $display("FAIL btu_vs_se0: got evts=%0d boot=%b expected 0 1",
                     evts, boot);
        end
    endtask

    initial begin
        test_reset_por("por1", 1'b0);
        test_short_se0;
        test_bus_reset;
        test_timeout;
        test_reset_por("boot_rst", 1'b1);
        test_sof_threshold;
        test_reset_por("por3", 1'b0);
        test_boot_in_busrst;
        test_reset_por("por4", 1'b0);
        test_boot_vs_se0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bootloader_reset_ctrl.md
BOOTLOADER_RESET_CTRL -- requirements
Module: bootloader_reset_ctrl

Interface
REQ-001 SHALL have parameter POR_CYCLES, default 4800, meaning power-on hold time in clk_48mhz cycles before pull-up enable (100 us).
REQ-002 SHALL have parameter SE0_RESET_CYCLES, default 120, meaning continuous SE0 cycles qualifying as USB bus reset (2.5 us).
REQ-003 SHALL have parameter HOST_TIMEOUT_CYCLES, default 48000000, meaning cycles without SOF before boot to user design (1 s).
REQ-004 SHALL have parameter DETACH_CYCLES, default 16, meaning cycles pull-up is released before boot asserts.
REQ-005 SHALL have port clk_48mhz, input, 1, meaning the single 48 MHz clock for all state.
REQ-006 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port dp_rx, input, 1, meaning raw D+ line sample, asynchronous to clk_48mhz.
REQ-008 SHALL have port dn_rx, input, 1, meaning raw D- line sample, asynchronous to clk_48mhz.
REQ-009 SHALL have port sof_valid, input, 1, meaning one-cycle pulse from protocol engine per received SOF.
REQ-010 SHALL have port boot_to_user_design, input, 1, meaning boot request from SPI bridge endpoint, level or pulse.
REQ-011 SHALL have port usb_reset, output, 1, meaning synchronous active-high reset to the USB engine and endpoints.
REQ-012 SHALL have port usb_pu_en, output, 1, meaning enable for the 1.5k D+ pull-up driver.
REQ-013 SHALL have port bus_reset_evt, output, 1, meaning one-cycle pulse per qualified bus reset.
REQ-014 SHALL have port host_presence_timeout, output, 1, meaning sticky flag that the SOF timeout expired.
REQ-015 SHALL have port boot, output, 1, meaning a level telling the FPGA to load the user configuration.

Function
REQ-016 SHALL synchronise dp_rx and dn_rx through two flops each; SE0 = both synchronised lines low.
REQ-017 SHALL implement states POR, ATTACH, BUSRST, DETACH, BOOT, all registered.
REQ-018 POR: usb_reset=1, usb_pu_en=0; count POR_CYCLES, then go to ATTACH on the next cycle.
REQ-019 ATTACH: usb_reset=0, usb_pu_en=1; SE0 counter increments per SE0 cycle, clears on any non-SE0 cycle, and saturates.
REQ-020 ATTACH: when the SE0 counter reaches SE0_RESET_CYCLES, go to BUSRST and pulse bus_reset_evt for exactly one cycle.
REQ-021 BUSRST: usb_reset=1, usb_pu_en=1, host timer held at 0; on the first synchronised non-SE0 cycle, return to ATTACH with the SE0 counter cleared.
REQ-022 Host timer: 32-bit, counts only in ATTACH, clears on sof_valid, saturates at HOST_TIMEOUT_CYCLES.
REQ-023 When the host timer equals HOST_TIMEOUT_CYCLES in ATTACH, set host_presence_timeout and go to DETACH.
REQ-024 boot_to_user_design=1 in ATTACH or BUSRST SHALL go to DETACH the next cycle; it is ignored in POR.
REQ-025 DETACH: usb_pu_en=0, usb_reset=1; count DETACH_CYCLES, then go to BOOT.
REQ-026 BOOT: boot=1, usb_pu_en=0, usb_reset=1; terminal state, left only by reset_n.
REQ-027 Simultaneous events, same cycle:
- sof_valid with timer at threshold: sof_valid wins; timer clears, no timeout.
- boot_to_user_design with SE0 qualification: DETACH wins; no bus_reset_evt.
REQ-028 host_presence_timeout, once set, SHALL remain 1 until reset_n.
REQ-029 All outputs SHALL be driven directly from flops (glitch-free).

Reset
REQ-030 reset_n low SHALL asynchronously force: state POR, all counters 0, synchroniser flops 0, usb_reset=1, usb_pu_en=0, bus_reset_evt=0, host_presence_timeout=0, boot=0.
REQ-031 Deassertion of reset_n SHALL be synchronised internally (two-flop release) before POR counting begins.
REQ-032 reset_n asserted mid-operation in any state, including BOOT, SHALL restart from POR with no output pulse.

Verification (POR_CYCLES=8, SE0_RESET_CYCLES=4, HOST_TIMEOUT_CYCLES=50, DETACH_CYCLES=3)
REQ-033 Release reset_n, lines idle J (dp=1, dn=0) -> usb_reset=1 and usb_pu_en=0 for POR plus sync cycles; then usb_pu_en=1 and usb_reset=0.
REQ-034 In ATTACH, drive SE0 for 3 cycles then J -> no bus_reset_evt; drive SE0 for 10 cycles -> exactly one bus_reset_evt pulse, usb_reset=1 until 2 cycles after J returns.
REQ-035 In ATTACH, sof_valid every 40 cycles -> no timeout; stop SOF -> host_presence_timeout=1 at cycle 50, usb_pu_en=0, boot=1 three cycles later.
REQ-036 Pulse boot_to_user_design for one cycle while in BUSRST -> DETACH, then BOOT; boot stays 1 for 1000 cycles with no further activity.
REQ-037 sof_valid coincident with timer=50 -> no timeout; assert reset_n low while in BOOT -> boot=0 immediately (asynchronous), POR sequence repeats.
